// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin writeback arbiter in front of the integer register file.
//   Each cycle it scans the requesters starting at rr_ptr. It grants up to
//   NR_WRITE_PORTS of them and never grants two writes to the same register
//   in the same cycle. Granted writes are registered and then driven onto
//   the register file write ports one cycle later.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          suppresses all grants this cycle and rewinds rr_ptr to 0
//   req_valid_i      per-requester write request
//   req_ready_o      per-requester grant (combinational)
//   req_waddr_i      per-requester destination register
//   req_wdata_i      per-requester write data
//   waddr_o          registered register-file write address, one per port
//   wdata_o          registered register-file write data, one per port
//   we_o             registered register-file write enable, one per port
//   grant_cnt_o      number of grants this cycle (combinational)
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 64,
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter bit ZERO_REG_ZERO  = 1'b0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic [NR_REQ-1:0]                            req_valid_i,
  output logic [NR_REQ-1:0]                            req_ready_o,
  input  logic [NR_REQ-1:0][4:0]                       req_waddr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]            req_wdata_i,
  output logic [NR_WRITE_PORTS-1:0][4:0]               waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_o,
  output logic [NR_WRITE_PORTS-1:0]                    we_o,
  output logic [$clog2(NR_WRITE_PORTS+1)-1:0]          grant_cnt_o
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CNT_W = $clog2(NR_WRITE_PORTS + 1);

  logic [PTR_W-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [NR_WRITE_PORTS-1:0][4:0]            waddr_q, waddr_d;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NR_WRITE_PORTS-1:0]                 we_q, we_d;

  // Scan-time working state
  int                             gnt_cnt;
  int                             idx_w;
  logic [PTR_W-1:0]               idx;
  logic [PTR_W-1:0]               last_idx;
  logic                           conflict;
  logic [NR_WRITE_PORTS-1:0][4:0] gnt_addr;

  // Rotating scan: the k-th grant in scan order lands on port k. Ports left
  // unused keep their address/data but drop we.
  always_comb begin
    req_ready_o = '0;
    gnt_cnt     = 0;
    gnt_addr    = '0;
    idx_w       = 0;
    idx         = '0;
    conflict    = 1'b0;
    last_idx    = rr_ptr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      idx_w = int'(rr_ptr_q) + k;
      if (idx_w >= NR_REQ) idx_w = idx_w - NR_REQ;
      idx = PTR_W'(idx_w);
      // Only addresses already granted this cycle take part in the check
      conflict = 1'b0;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        if (p < gnt_cnt && gnt_addr[p] == req_waddr_i[idx]) conflict = 1'b1;
      end
      if (!flush_i && req_valid_i[idx] && gnt_cnt < NR_WRITE_PORTS && !conflict) begin
        req_ready_o[idx] = 1'b1;
        last_idx         = idx;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (p == gnt_cnt) begin
            gnt_addr[p] = req_waddr_i[idx];
            waddr_d[p]  = req_waddr_i[idx];
            wdata_d[p]  = req_wdata_i[idx];
            // x0 still consumes a slot and blocks a second x0 write; it is
            // just never enabled on the register file.
            we_d[p]     = !(ZERO_REG_ZERO && req_waddr_i[idx] == 5'd0);
          end
        end
        gnt_cnt = gnt_cnt + 1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush_i)           rr_ptr_d = '0;
    else if (gnt_cnt != 0) rr_ptr_d = (last_idx == PTR_W'(NR_REQ - 1)) ? '0
                                                                        : last_idx + PTR_W'(1);
  end

  assign grant_cnt_o = CNT_W'(gnt_cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [3:0]       valid;
  logic [3:0][4:0]  waddr;
  logic [3:0][63:0] wdata;

  logic [3:0]       rdy0, rdy1;
  logic [1:0][4:0]  wa0, wa1;
  logic [1:0][63:0] wd0, wd1;
  logic [1:0]       we0, we1;
  logic [1:0]       cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // dut0: x0 is an ordinary register; dut1: x0 writes are never enabled
  regfile_wb_arbiter #(.DATA_WIDTH(64), .NR_REQ(4), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(valid), .req_ready_o(rdy0),
    .req_waddr_i(waddr), .req_wdata_i(wdata), .waddr_o(wa0), .wdata_o(wd0), .we_o(we0),
    .grant_cnt_o(cnt0));

  regfile_wb_arbiter #(.DATA_WIDTH(64), .NR_REQ(4), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(valid), .req_ready_o(rdy1),
    .req_waddr_i(waddr), .req_wdata_i(wdata), .waddr_o(wa1), .wdata_o(wd1), .we_o(we1),
    .grant_cnt_o(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs applied after the rising edge, outputs
  // checked on the falling edge. we/waddr/wdata are the registered results
  // of the previous cycle's grants.
  typedef struct {
    logic             flush;
    logic [3:0]       valid;
    logic [3:0][4:0]  addr;
    logic [3:0][15:0] data;
    logic [3:0]       ready;
    logic [1:0]       cnt;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][15:0] wdata;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic [3:0] v, input logic [19:0] a,
                              input logic [63:0] d, input logic [3:0] r, input logic [1:0] c,
                              input logic [1:0] w, input logic [9:0] wa, input logic [31:0] wd);
    vec_t m;
    m.flush = f; m.valid = v; m.addr = a; m.data = d;
    m.ready = r; m.cnt = c; m.we = w; m.waddr = wa; m.wdata = wd;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [3:0] v, input logic [19:0] a, input logic [63:0] d);
    vec_t m;
    m.addr = a; m.data = d;
    flush = f; valid = v;
    for (int r = 0; r < 4; r++) begin
      waddr[r] = m.addr[r];
      wdata[r] = 64'(m.data[r]);
    end
  endtask

  localparam logic [19:0] A4 = {5'd10, 5'd9, 5'd2, 5'd1};
  localparam logic [63:0] D4 = {16'h400, 16'h300, 16'h200, 16'h100};
  localparam logic [19:0] AC = {5'd10, 5'd6, 5'd5, 5'd5};
  localparam logic [63:0] DC = {16'h400, 16'h600, 16'h501, 16'h500};
  localparam logic [19:0] A2 = {5'd0, 5'd0, 5'd7, 5'd3};
  localparam logic [63:0] D2 = {16'h0, 16'h0, 16'hB, 16'hA};

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(0, 4'b0011, A2, D2, 4'b0011, 2, 2'b00, {5'd0, 5'd0},  {16'h0, 16'h0});
    vecs[1]  = mk(0, 4'b0000, A2, D2, 4'b0000, 0, 2'b11, {5'd7, 5'd3},  {16'hB, 16'hA});
    vecs[2]  = mk(0, 4'b1111, A4, D4, 4'b1100, 2, 2'b00, {5'd7, 5'd3},  {16'hB, 16'hA});
    vecs[3]  = mk(0, 4'b1111, A4, D4, 4'b0011, 2, 2'b11, {5'd10, 5'd9}, {16'h400, 16'h300});
    vecs[4]  = mk(0, 4'b1111, A4, D4, 4'b1100, 2, 2'b11, {5'd2, 5'd1},  {16'h200, 16'h100});
    vecs[5]  = mk(0, 4'b0111, AC, DC, 4'b0101, 2, 2'b11, {5'd10, 5'd9}, {16'h400, 16'h300});
    vecs[6]  = mk(0, 4'b0010, AC, DC, 4'b0010, 1, 2'b11, {5'd6, 5'd5},  {16'h600, 16'h500});
    vecs[7]  = mk(0, 4'b0000, AC, DC, 4'b0000, 0, 2'b01, {5'd6, 5'd5},  {16'h600, 16'h501});
    vecs[8]  = mk(0, 4'b0110, A4, D4, 4'b0110, 2, 2'b00, {5'd6, 5'd5},  {16'h600, 16'h501});
    vecs[9]  = mk(1, 4'b1111, A4, D4, 4'b0000, 0, 2'b11, {5'd2, 5'd9},  {16'h200, 16'h300});
    vecs[10] = mk(0, 4'b1111, A4, D4, 4'b0011, 2, 2'b00, {5'd2, 5'd9},  {16'h200, 16'h300});
    vecs[11] = mk(0, 4'b0000, A4, D4, 4'b0000, 0, 2'b11, {5'd2, 5'd1},  {16'h200, 16'h100});

    // Reset: registered outputs zero, grant logic live with rr_ptr = 0
    rst_n = 1'b0;
    drive(0, 4'b1111, A4, D4);
    #2;
    chk("rst_we",    64'(we0), 64'(2'b00));
    chk("rst_waddr", 64'(wa0), 64'(10'd0));
    chk("rst_wdata", wd0[0] | wd0[1], 64'd0);
    chk("rst_ready", 64'(rdy0), 64'(4'b0011));
    chk("rst_cnt",   64'(cnt0), 64'd2);
    @(negedge clk);
    drive(0, 4'b0000, A4, D4);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].flush, vecs[i].valid, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(rdy0), 64'(vecs[i].ready));
      chk($sformatf("v%0d_cnt", i),   64'(cnt0), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_we", i),    64'(we0),  64'(vecs[i].we));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("v%0d_waddr%0d", i, p), 64'(wa0[p]), 64'(vecs[i].waddr[p]));
        chk($sformatf("v%0d_wdata%0d", i, p), wd0[p],       64'(vecs[i].wdata[p]));
      end
    end

    // x0 write with rr_ptr = 2: port0 = req0 (x0), port1 = req1 (x4)
    @(posedge clk); #1;
    drive(0, 4'b0011, {5'd0, 5'd0, 5'd4, 5'd0}, {16'h0, 16'h0, 16'hB0, 16'hA0});
    @(negedge clk);
    chk("x0_ready_z0", 64'(rdy0), 64'(4'b0011));
    chk("x0_ready_z1", 64'(rdy1), 64'(4'b0011));
    @(posedge clk); #1;
    drive(0, 4'b0000, {5'd0, 5'd0, 5'd4, 5'd0}, {16'h0, 16'h0, 16'hB0, 16'hA0});
    @(negedge clk);
    chk("x0_we_z0",    64'(we0),   64'(2'b11));
    chk("x0_we_z1",    64'(we1),   64'(2'b10));
    chk("x0_waddr1",   64'(wa1[1]), 64'd4);
    chk("x0_wdata1",   wd1[1],     64'hB0);

    // Two x0 writes collide even when x0 is never enabled
    @(posedge clk); #1;
    drive(0, 4'b0011, {5'd0, 5'd0, 5'd0, 5'd0}, {16'h0, 16'h0, 16'hB1, 16'hA1});
    @(negedge clk);
    chk("x0c_ready_z1", 64'(rdy1), 64'(4'b0001));
    chk("x0c_cnt_z1",   64'(cnt1), 64'd1);

    // rr_ptr now 1: grants {1,2}
    @(posedge clk); #1;
    drive(0, 4'b1111, A4, D4);
    @(negedge clk);
    chk("pre_we_z0", 64'(we0), 64'(2'b01));
    chk("pre_we_z1", 64'(we1), 64'(2'b00));
    chk("pre_ready", 64'(rdy0), 64'(4'b0110));

    // Mid-stream reset with both ports enabled
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_we_before", 64'(we0), 64'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_we",    64'(we0), 64'(2'b00));
    chk("mid_waddr", 64'(wa0), 64'(10'd0));
    chk("mid_wdata", wd0[0] | wd0[1], 64'd0);
    chk("mid_ready", 64'(rdy0), 64'(4'b0011));
    @(posedge clk); #1;
    chk("mid_we_held", 64'(we0), 64'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 4'b0000, A4, D4);
    @(negedge clk);
    chk("post_we",    64'(we0), 64'(2'b11));
    chk("post_waddr", 64'(wa0), 64'({5'd2, 5'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
